memory_stage: RTL and testbench

Y86-64 pipeline Memory (M) stage. It consumes the E->M pipeline register outputs and performs the data-memory access for memory-class instructions over a request/ready handshake to an external data memory. It stalls the pipeline while an access is outstanding and delivers a registered valM and stat toward the M->W register. Out-of-range addresses are flagged as ADR.

---
 rtl/memory_stage.sv | 170 +++++++++++++++++
 tb/tb_memory_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Y86-64 Memory stage: runs data-memory accesses over a req/ready handshake and
// produces the registered valM/stat for the M->W register. Optional MEM_TIMEOUT_EN.
module memory_stage #(
    parameter int unsigned MEM_BYTES      = 4096,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_valid,
    input  logic [2:0]  stat_m,
    input  logic [3:0]  icode_m,
    input  logic [63:0] valA_m,
    input  logic [63:0] valE_m,
    input  logic [63:0] valp_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    input  logic [63:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        stall_m,
    output logic        out_valid,
    output logic [63:0] valM_out,
    output logic [2:0]  stat_out
);

    localparam logic [2:0]  STAT_AOK = 3'd1;
    localparam logic [2:0]  STAT_ADR = 3'd3;
    localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

    typedef enum logic {IDLE, REQ} state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] valm_q, valm_d;
    logic [2:0]  stat_q, stat_d;

    logic        is_write_c, is_read_c, mem_op_c, addr_ok_c, start_c, timeout_c;
    logic [63:0] addr_c, wdata_c;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_c = 1'b0;
`endif

    // Instruction decode: direction, address source and write-data source
    always_comb begin
        is_write_c = 1'b0;
        is_read_c  = 1'b0;
        addr_c     = valE_m;
        wdata_c    = valA_m;
        case (icode_m)
            4'h4, 4'hA: is_write_c = 1'b1;
            4'h8: begin
                is_write_c = 1'b1;
                wdata_c    = valp_m;
            end
            4'h5: is_read_c = 1'b1;
            4'h9, 4'hB: begin
                is_read_c = 1'b1;
                addr_c    = valA_m;
            end
            default: ;
        endcase
    end

    assign mem_op_c  = is_write_c | is_read_c;
    assign addr_ok_c = (addr_c <= ADDR_MAX);
    assign start_c   = (state_q == IDLE) & m_valid & mem_op_c & (stat_m == STAT_AOK) & addr_ok_c;

    // Next-state, request and result logic
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        out_valid_d = 1'b0;
        valm_d      = valm_q;
        stat_d      = stat_q;
        stall_m     = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_c) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    we_d    = is_write_c;
                    addr_d  = addr_c;
                    wdata_d = wdata_c;
                    stall_m = 1'b1;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else if (m_valid) begin
                    out_valid_d = 1'b1;
                    valm_d      = '0;
                    stat_d      = (mem_op_c && stat_m == STAT_AOK && !addr_ok_c) ? STAT_ADR : stat_m;
                end
            end
            REQ: begin
                if (dmem_ready) begin
                    state_d     = IDLE;
                    req_d       = 1'b0;
                    out_valid_d = 1'b1;
                    valm_d      = we_q ? 64'd0 : dmem_rdata;
                    stat_d      = STAT_AOK;
                end else if (timeout_c) begin
                    state_d     = IDLE;
                    req_d       = 1'b0;
                    out_valid_d = 1'b1;
                    valm_d      = '0;
                    stat_d      = STAT_ADR;
                end else begin
                    stall_m = 1'b1;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            out_valid_q <= 1'b0;
            valm_q      <= '0;
            stat_q      <= STAT_AOK;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            out_valid_q <= out_valid_d;
            valm_q      <= valm_d;
            stat_q      <= stat_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign out_valid  = out_valid_q;
    assign valM_out   = valm_q;
    assign stat_out   = stat_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: inputs driven and outputs sampled on the falling edge.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_valid;
    logic [2:0]  stat_m;
    logic [3:0]  icode_m;
    logic [63:0] valA_m, valE_m, valp_m;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ready;
    logic        stall_m, out_valid;
    logic [63:0] valM_out;
    logic [2:0]  stat_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    memory_stage #(.MEM_BYTES(4096), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .m_valid(m_valid), .stat_m(stat_m), .icode_m(icode_m),
        .valA_m(valA_m), .valE_m(valE_m), .valp_m(valp_m),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .stall_m(stall_m),
        .out_valid(out_valid), .valM_out(valM_out), .stat_out(stat_out)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue(input logic [3:0] ic, input logic [2:0] st,
                         input logic [63:0] a, input logic [63:0] e, input logic [63:0] p);
        m_valid = 1'b1; icode_m = ic; stat_m = st; valA_m = a; valE_m = e; valp_m = p;
    endtask

    task automatic test_reset();
        rst = 1'b1; m_valid = 1'b0; stat_m = 3'd1; icode_m = 4'h0;
        valA_m = '0; valE_m = '0; valp_m = '0; dmem_rdata = '0; dmem_ready = 1'b0;
        step(); step();
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", dmem_req); end
        checks++; if (dmem_we !== 1'b0 || dmem_addr !== 64'd0 || dmem_wdata !== 64'd0) begin
            errors++; $display("FAIL reset_bus: we=%0b addr=%h wdata=%h want 0", dmem_we, dmem_addr, dmem_wdata); end
        checks++; if (out_valid !== 1'b0 || valM_out !== 64'd0) begin
            errors++; $display("FAIL reset_out: valid=%0b valM=%h want 0/0", out_valid, valM_out); end
        checks++; if (stat_out !== 3'd1) begin errors++; $display("FAIL reset_stat: got %0d want 1", stat_out); end
        rst = 1'b0;
    endtask

    task automatic test_store_wait3();
        issue(4'h4, 3'd1, 64'hDEADBEEF, 64'h100, 64'h0);
        #1;
        checks++; if (stall_m !== 1'b1) begin errors++; $display("FAIL store_stall_start: got %0b want 1", stall_m); end
        step();
        m_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 64'h100 || dmem_wdata !== 64'hDEADBEEF) begin
                errors++; $display("FAIL store_bus%0d: req=%0b we=%0b addr=%h wdata=%h want 1/1/100/deadbeef",
                                   i, dmem_req, dmem_we, dmem_addr, dmem_wdata); end
            checks++; if (stall_m !== 1'b1) begin errors++; $display("FAIL store_stall%0d: got %0b want 1", i, stall_m); end
            step();
        end
        dmem_ready = 1'b1;
        #1;
        checks++; if (stall_m !== 1'b0) begin errors++; $display("FAIL store_stall_ready: got %0b want 0", stall_m); end
        step();
        dmem_ready = 1'b0;
        checks++; if (out_valid !== 1'b1 || valM_out !== 64'd0 || stat_out !== 3'd1 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL store_done: valid=%0b valM=%h stat=%0d req=%0b want 1/0/1/0",
                               out_valid, valM_out, stat_out, dmem_req); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL store_pulse: got %0b want 0", out_valid); end
    endtask

    task automatic test_pop_fast();
        issue(4'hB, 3'd1, 64'h200, 64'h208, 64'h0);
        step();
        m_valid = 1'b0;
        checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 64'h200) begin
            errors++; $display("FAIL pop_bus: req=%0b we=%0b addr=%h want 1/0/200", dmem_req, dmem_we, dmem_addr); end
        dmem_ready = 1'b1; dmem_rdata = 64'h1122334455667788;
        #1;
        checks++; if (stall_m !== 1'b0) begin errors++; $display("FAIL pop_stall: got %0b want 0", stall_m); end
        step();
        dmem_ready = 1'b0; dmem_rdata = 64'h0;
        checks++; if (out_valid !== 1'b1 || valM_out !== 64'h1122334455667788 || stat_out !== 3'd1) begin
            errors++; $display("FAIL pop_done: valid=%0b valM=%h stat=%0d want 1/1122334455667788/1",
                               out_valid, valM_out, stat_out); end
    endtask

    task automatic test_bounds();
        step();
        issue(4'h5, 3'd1, 64'h0, 64'hFF9, 64'h0);
        #1;
        checks++; if (stall_m !== 1'b0) begin errors++; $display("FAIL oob_stall: got %0b want 0", stall_m); end
        step();
        m_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || stat_out !== 3'd3 || valM_out !== 64'd0 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL oob_out: valid=%0b stat=%0d valM=%h req=%0b want 1/3/0/0",
                               out_valid, stat_out, valM_out, dmem_req); end
        issue(4'h5, 3'd1, 64'h0, 64'hFF8, 64'h0);
        step();
        m_valid = 1'b0;
        checks++; if (dmem_req !== 1'b1 || dmem_addr !== 64'hFF8) begin
            errors++; $display("FAIL edge_req: req=%0b addr=%h want 1/ff8", dmem_req, dmem_addr); end
        dmem_ready = 1'b1; dmem_rdata = 64'hA5A5_0000_1234_5678;
        step();
        dmem_ready = 1'b0;
        checks++; if (out_valid !== 1'b1 || valM_out !== 64'hA5A5_0000_1234_5678 || stat_out !== 3'd1) begin
            errors++; $display("FAIL edge_done: valid=%0b valM=%h stat=%0d want 1/a5a5000012345678/1",
                               out_valid, valM_out, stat_out); end
        issue(4'h9, 3'd1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0);
        step();
        m_valid = 1'b0;
        checks++; if (dmem_req !== 1'b0 || stat_out !== 3'd3 || out_valid !== 1'b1) begin
            errors++; $display("FAIL ret_oob: req=%0b stat=%0d valid=%0b want 0/3/1", dmem_req, stat_out, out_valid); end
    endtask

    task automatic test_passthrough();
        issue(4'h6, 3'd1, 64'h5, 64'h7, 64'h9);
        #1;
        checks++; if (stall_m !== 1'b0) begin errors++; $display("FAIL opq_stall: got %0b want 0", stall_m); end
        step();
        checks++; if (out_valid !== 1'b1 || stat_out !== 3'd1 || valM_out !== 64'd0 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL opq_out: valid=%0b stat=%0d valM=%h req=%0b want 1/1/0/0",
                               out_valid, stat_out, valM_out, dmem_req); end
        issue(4'h4, 3'd2, 64'h1, 64'h100, 64'h0);
        step();
        checks++; if (out_valid !== 1'b1 || stat_out !== 3'd2 || valM_out !== 64'd0 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL hlt_out: valid=%0b stat=%0d valM=%h req=%0b want 1/2/0/0",
                               out_valid, stat_out, valM_out, dmem_req); end
        m_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || stat_out !== 3'd2) begin
            errors++; $display("FAIL idle_hold: valid=%0b stat=%0d want 0/2", out_valid, stat_out); end
    endtask

    task automatic test_back_to_back();
        issue(4'h8, 3'd1, 64'h11, 64'h300, 64'h1234);
        step();
        m_valid = 1'b0;
        checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 64'h300 || dmem_wdata !== 64'h1234) begin
            errors++; $display("FAIL call_bus: req=%0b we=%0b addr=%h wdata=%h want 1/1/300/1234",
                               dmem_req, dmem_we, dmem_addr, dmem_wdata); end
        dmem_ready = 1'b1;
        step();
        dmem_ready = 1'b0;
        issue(4'hA, 3'd1, 64'hCAFE, 64'h2F8, 64'h0);
        #1;
        checks++; if (out_valid !== 1'b1 || stall_m !== 1'b1) begin
            errors++; $display("FAIL b2b_turn: valid=%0b stall=%0b want 1/1", out_valid, stall_m); end
        step();
        m_valid = 1'b0;
        checks++; if (dmem_req !== 1'b1 || dmem_addr !== 64'h2F8 || dmem_wdata !== 64'hCAFE || out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_push: req=%0b addr=%h wdata=%h valid=%0b want 1/2f8/cafe/0",
                               dmem_req, dmem_addr, dmem_wdata, out_valid); end
        dmem_ready = 1'b1;
        step();
        dmem_ready = 1'b0;
        checks++; if (out_valid !== 1'b1 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL b2b_done: valid=%0b req=%0b want 1/0", out_valid, dmem_req); end
    endtask

    task automatic test_reset_mid_req();
        issue(4'h5, 3'd1, 64'h0, 64'h40, 64'h0);
        step();
        m_valid = 1'b0;
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rstreq_start: got %0b want 1", dmem_req); end
        rst = 1'b1;
        step();
        checks++; if (dmem_req !== 1'b0 || out_valid !== 1'b0 || stat_out !== 3'd1) begin
            errors++; $display("FAIL rstreq_abort: req=%0b valid=%0b stat=%0d want 0/0/1", dmem_req, out_valid, stat_out); end
        step();
        rst = 1'b0;
        dmem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b0 || dmem_req !== 1'b0) begin
                errors++; $display("FAIL rstreq_quiet%0d: valid=%0b req=%0b want 0/0", i, out_valid, dmem_req); end
        end
        dmem_ready = 1'b0;
    endtask

    task automatic test_long_wait();
        int n;
        issue(4'h9, 3'd1, 64'h80, 64'h0, 64'h0);
        step();
        m_valid = 1'b0;
        n = 0;
        while (dmem_req === 1'b1 && n < 40) begin
            n++;
            step();
        end
`ifdef MEM_TIMEOUT_EN
        checks++; if (n !== 16) begin errors++; $display("FAIL timeout_len: got %0d want 16", n); end
        checks++; if (out_valid !== 1'b1 || stat_out !== 3'd3 || valM_out !== 64'd0) begin
            errors++; $display("FAIL timeout_out: valid=%0b stat=%0d valM=%h want 1/3/0", out_valid, stat_out, valM_out); end
`else
        checks++; if (n !== 40 || stall_m !== 1'b1) begin
            errors++; $display("FAIL wait_len: cycles=%0d stall=%0b want 40/1", n, stall_m); end
        dmem_ready = 1'b1; dmem_rdata = 64'h0BAD_F00D;
        step();
        dmem_ready = 1'b0;
        checks++; if (out_valid !== 1'b1 || valM_out !== 64'h0BAD_F00D || stat_out !== 3'd1) begin
            errors++; $display("FAIL wait_done: valid=%0b valM=%h stat=%0d want 1/badf00d/1", out_valid, valM_out, stat_out); end
`endif
    endtask

    initial begin
        test_reset();
        test_store_wait3();
        test_pop_fast();
        test_bounds();
        test_passthrough();
        test_back_to_back();
        test_reset_mid_req();
        test_long_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
